// File: rtl/spi_byte_fifo.sv
// Byte FIFO behind the SPI peripheral: WRITE pushes operands, READ pops them as response bytes, STATUS/CLEAR manage it.
// Latency: state 2 cycles after opcode rise, first response byte same edge; pop shows next head 2 cycles after operand rise.
// Backpressure: none; pushes into a full FIFO are dropped and latch overflow, pops from empty are no-ops.
module spi_byte_fifo #(
    parameter logic [7:0] WRITE_OPCODE  = 8'h20,
    parameter logic [7:0] READ_OPCODE   = 8'h21,
    parameter logic [7:0] STATUS_OPCODE = 8'h22,
    parameter logic [7:0] CLEAR_OPCODE  = 8'h23,
    parameter int         DEPTH         = 64
) (
    input  logic       clock_in,
    input  logic       reset_n_in,
    input  logic [7:0] opcode_in,
    input  logic       opcode_valid_in,
    input  logic [7:0] operand_in,
    input  logic       operand_valid_in,
    output logic [7:0] response_out,
    output logic       response_valid_out,
    output logic [6:0] level_out,
    output logic       full_out,
    output logic       empty_out,
    output logic       overflow_out
);

    localparam int             PW      = $clog2(DEPTH);
    localparam logic [6:0]     DEPTH_L = 7'(DEPTH);
    localparam logic [PW-1:0]  LAST    = PW'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WRITE, S_READ, S_STATUS, S_CLEAR, S_IGNORE
    } state_t;

    state_t        state;
    logic          opc_vld_q, opc_vld_qq, opd_vld_q, opd_vld_qq;
    logic [7:0]    opc_q, opd_q;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [6:0]    level;
    logic          overflow;
    logic [7:0]    mem [DEPTH];

    logic          opc_rise, opd_rise, push, pop, drop;
    logic [7:0]    head;

    assign opc_rise = opc_vld_q & ~opc_vld_qq;
    assign opd_rise = opd_vld_q & ~opd_vld_qq;
    assign push     = (state == S_WRITE) && opc_vld_q && opd_rise && (level != DEPTH_L);
    assign drop     = (state == S_WRITE) && opc_vld_q && opd_rise && (level == DEPTH_L);
    assign pop      = (state == S_READ)  && opc_vld_q && opd_rise && (level != 7'd0);
    assign head     = (level == 7'd0) ? 8'h00 : mem[rd_ptr];

    assign level_out    = level;
    assign full_out     = (level == DEPTH_L);
    assign empty_out    = (level == 7'd0);
    assign overflow_out = overflow;

    // Storage carries no reset so it can map onto RAM; pointers/level define validity.
    always_ff @(posedge clock_in) begin
        if (push) begin
            mem[wr_ptr] <= opd_q;
        end
    end

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state              <= S_IDLE;
            opc_vld_q          <= 1'b0;
            opc_vld_qq         <= 1'b0;
            opd_vld_q          <= 1'b0;
            opd_vld_qq         <= 1'b0;
            opc_q              <= 8'h00;
            opd_q              <= 8'h00;
            wr_ptr             <= '0;
            rd_ptr             <= '0;
            level              <= 7'd0;
            overflow           <= 1'b0;
            response_out       <= 8'h00;
            response_valid_out <= 1'b0;
        end else begin
            opc_vld_q  <= opcode_valid_in;
            opc_vld_qq <= opc_vld_q;
            opd_vld_q  <= operand_valid_in;
            opd_vld_qq <= opd_vld_q;
            opc_q      <= opcode_in;
            opd_q      <= operand_in;

            if (push) begin
                wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
                level  <= level + 7'd1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
                level  <= level - 7'd1;
            end
            if (state == S_CLEAR) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                level    <= 7'd0;
                overflow <= 1'b0;
            end

            if (state == S_IDLE) begin
                response_out       <= 8'h00;
                response_valid_out <= 1'b0;
                if (opc_rise) begin
                    if (opc_q == WRITE_OPCODE) begin
                        state <= S_WRITE;
                    end else if (opc_q == READ_OPCODE) begin
                        state              <= S_READ;
                        response_out       <= head;
                        response_valid_out <= 1'b1;
                    end else if (opc_q == STATUS_OPCODE) begin
                        state              <= S_STATUS;
                        response_out       <= {overflow, level};
                        response_valid_out <= 1'b1;
                    end else if (opc_q == CLEAR_OPCODE) begin
                        state <= S_CLEAR;
                    end else begin
                        state <= S_IGNORE;
                    end
                end
            end else if (!opc_vld_q) begin
                state              <= S_IDLE;
                response_out       <= 8'h00;
                response_valid_out <= 1'b0;
            end else begin
                case (state)
                    S_READ:  response_out <= head;
                    S_CLEAR: state        <= S_IGNORE;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_byte_fifo.sv
// Bench for spi_byte_fifo: directed scenarios plus random transactions against a queue-based model.
module tb_spi_byte_fifo;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset_n_in;
    logic [7:0] opcode_in;
    logic       opcode_valid_in;
    logic [7:0] operand_in;
    logic       operand_valid_in;
    logic [7:0] response_out;
    logic       response_valid_out;
    logic [6:0] level_out;
    logic       full_out;
    logic       empty_out;
    logic       overflow_out;

    always #5 clk = ~clk;

    spi_byte_fifo #(.DEPTH(DEPTH)) dut (
        .clock_in           (clk),
        .reset_n_in         (reset_n_in),
        .opcode_in          (opcode_in),
        .opcode_valid_in    (opcode_valid_in),
        .operand_in         (operand_in),
        .operand_valid_in   (operand_valid_in),
        .response_out       (response_out),
        .response_valid_out (response_valid_out),
        .level_out          (level_out),
        .full_out           (full_out),
        .empty_out          (empty_out),
        .overflow_out       (overflow_out)
    );

    int          vectors     = 0;
    int          miscompares = 0;
    byte unsigned q[$];
    bit          ovf;
    logic [7:0]  cur_op;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] status_exp();
        return {ovf, 7'(q.size())};
    endfunction

    function automatic bit is_resp(input logic [7:0] op);
        return (op == 8'h21) || (op == 8'h22);
    endfunction

    task automatic check_flags(input string tag);
        chk({tag, "_level"}, 32'(level_out), 32'(q.size()));
        chk({tag, "_empty"}, 32'(empty_out), 32'(q.size() == 0));
        chk({tag, "_full"},  32'(full_out),  32'(q.size() == DEPTH));
        chk({tag, "_ovf"},   32'(overflow_out), 32'(ovf));
    endtask

    task automatic t_start(input logic [7:0] op);
        @(negedge clk);
        opcode_in       = op;
        opcode_valid_in = 1'b1;
        cur_op          = op;
        repeat (3) @(negedge clk);
        chk("resp_vld_start", 32'(response_valid_out), 32'(is_resp(op)));
        if (op == 8'h22) chk("status", 32'(response_out), 32'(status_exp()));
        if (op == 8'h23) begin
            q.delete();
            ovf = 1'b0;
        end
    endtask

    task automatic t_slot(input logic [7:0] b);
        if (cur_op == 8'h21)
            chk("read_byte", 32'(response_out), (q.size() != 0) ? 32'(q[0]) : 32'h0);
        if (cur_op == 8'h22)
            chk("status_hold", 32'(response_out), 32'(status_exp()));
        operand_in       = b;
        operand_valid_in = 1'b1;
        repeat (2) @(negedge clk);
        operand_valid_in = 1'b0;
        repeat (4) @(negedge clk);
        if (cur_op == 8'h20) begin
            if (q.size() == DEPTH) ovf = 1'b1;
            else q.push_back(b);
        end else if (cur_op == 8'h21) begin
            if (q.size() != 0) void'(q.pop_front());
        end
        check_flags("slot");
        chk("resp_vld_slot", 32'(response_valid_out), 32'(is_resp(cur_op)));
    endtask

    task automatic t_end();
        opcode_valid_in = 1'b0;
        repeat (2) @(negedge clk);
        chk("resp_vld_end", 32'(response_valid_out), 32'h0);
        repeat (2) @(negedge clk);
    endtask

    task automatic txn(input logic [7:0] op, input int n, input logic [7:0] base);
        t_start(op);
        for (int i = 0; i < n; i++) t_slot(base + 8'(i));
        t_end();
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_resp"},  32'(response_out), 32'h0);
        chk({tag, "_rvld"},  32'(response_valid_out), 32'h0);
        chk({tag, "_level"}, 32'(level_out), 32'h0);
        chk({tag, "_empty"}, 32'(empty_out), 32'h1);
        chk({tag, "_full"},  32'(full_out), 32'h0);
        chk({tag, "_ovf"},   32'(overflow_out), 32'h0);
    endtask

    initial begin
        reset_n_in       = 1'b0;
        opcode_in        = 8'h00;
        opcode_valid_in  = 1'b0;
        operand_in       = 8'h00;
        operand_valid_in = 1'b0;
        ovf              = 1'b0;
        cur_op           = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        reset_n_in = 1'b1;
        repeat (2) @(negedge clk);

        // write then read back three bytes
        txn(8'h20, 3, 8'h11);
        chk("wr3_level", 32'(level_out), 32'd3);
        t_start(8'h21);
        t_slot(8'h00); t_slot(8'h00); t_slot(8'h00);
        t_end();
        chk("rd3_empty", 32'(empty_out), 32'h1);

        // read while empty
        txn(8'h21, 2, 8'h00);

        // overflow with a 4-deep FIFO
        txn(8'h20, 6, 8'hA0);
        chk("ovf_full", 32'(full_out), 32'h1);
        chk("ovf_flag", 32'(overflow_out), 32'h1);
        t_start(8'h22);
        chk("status_84", 32'(response_out), 32'h84);
        t_end();
        txn(8'h21, 4, 8'h00);

        // clear restores empty, non-overflowed state
        txn(8'h23, 0, 8'h00);
        t_start(8'h22);
        chk("status_after_clear", 32'(response_out), 32'h00);
        t_end();

        // pointer wrap: write-2/read-2 five times
        for (int k = 0; k < 5; k++) begin
            txn(8'h20, 2, 8'(8'h30 + 8'(k * 2)));
            txn(8'h21, 2, 8'h00);
            chk("wrap_level", 32'(level_out), 32'h0);
        end

        // reset in the middle of a read
        txn(8'h20, 3, 8'h51);
        t_start(8'h21);
        t_slot(8'h00);
        @(negedge clk);
        reset_n_in = 1'b0;
        #1;
        check_reset_vals("midreset");
        q.delete();
        ovf = 1'b0;
        opcode_valid_in = 1'b0;
        @(negedge clk);
        reset_n_in = 1'b1;
        repeat (2) @(negedge clk);
        t_start(8'h22);
        chk("status_after_reset", 32'(response_out), 32'h00);
        t_end();

        // unmatched opcode leaves FIFO untouched
        txn(8'h20, 1, 8'h77);
        txn(8'hDB, 2, 8'h90);
        check_flags("ignore");

        // randomized transactions
        for (int r = 0; r < 40; r++) begin
            logic [7:0] op;
            int         n;
            case ($urandom_range(0, 4))
                0:       op = 8'h20;
                1:       op = 8'h21;
                2:       op = 8'h22;
                3:       op = 8'h23;
                default: op = 8'($urandom);
            endcase
            n = int'($urandom_range(0, 5));
            t_start(op);
            for (int i = 0; i < n; i++) t_slot(8'($urandom));
            t_end();
        end
        check_flags("final");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
